// File: rtl/axi4_rr_burst_arbiter_pkg.sv
// Shared types and defaults for the round-robin burst arbiter.
// Optional feature macro used by the top: ARB_TIMEOUT_EN (forced release from ARB_DATA).
package axi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  localparam int ARB_TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/axi4_rr_burst_arbiter_if.sv
// Request/grant bundle between the requesting side and the arbiter.
// slave: arbiter view; master: requester/interconnect view.
interface axi4_rr_burst_arbiter_if #(
  parameter int NUM   = 8,
  parameter int NSIZE = $clog2(NUM)
);
  logic [NUM-1:0]   req;
  logic             addr_hs;
  logic             release_evt;
  logic [NSIZE-1:0] grant_idx;
  logic             grant_vld;
  logic [NUM-1:0]   grant_oh;
  logic             busy;
  logic             timeout_err;

  modport slave (
    input  req, addr_hs, release_evt,
    output grant_idx, grant_vld, grant_oh, busy, timeout_err
  );

  modport master (
    output req, addr_hs, release_evt,
    input  grant_idx, grant_vld, grant_oh, busy, timeout_err
  );
endinterface

// File: rtl/axi4_rr_burst_arbiter_pick.sv
// Combinational round-robin pick: first set request bit scanning from rr_ptr
// upward and wrapping NUM-1 -> 0. NUM need not be a power of two.
module arb_rr_pick #(
  parameter int NUM   = 8,
  parameter int NSIZE = $clog2(NUM)
) (
  input  logic [NUM-1:0]   req,
  input  logic [NSIZE-1:0] rr_ptr,
  output logic [NSIZE-1:0] winner,
  output logic             found
);

  int idx;

  // Walk NUM offsets from rr_ptr; the first requester hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < NUM; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM) idx = idx - NUM;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = NSIZE'(idx);
      end
    end
  end

endmodule

// File: rtl/axi4_rr_burst_arbiter.sv
// Round-robin burst arbiter: grants one master from address phase until
// completion so interconnect routing stays stable for the whole burst.
// Optional macro ARB_TIMEOUT_EN adds a forced release after TIMEOUT cycles
// in ARB_DATA with a one-cycle timeout_err pulse.
module axi4_rr_burst_arbiter
  import axi_arb_pkg::*;
#(
  parameter int NUM     = 8,
  parameter int NSIZE   = $clog2(NUM),
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic                   clock,
  input  logic                   rst_n,
  axi4_rr_burst_arbiter_if.slave arb
);

  if (NUM < 2 || TIMEOUT < 2) begin : g_bad_cfg
    $error("axi4_rr_burst_arbiter: NUM and TIMEOUT must both be >= 2");
  end

  arb_state_e       state_q, state_d;
  logic [NSIZE-1:0] rr_ptr_q, rr_ptr_d;
  logic [NSIZE-1:0] grant_idx_q, grant_idx_d;
  logic             grant_vld_q, grant_vld_d;
  logic [NUM-1:0]   grant_oh_q, grant_oh_d;
  logic             busy_q, busy_d;
  logic [NSIZE-1:0] winner;
  logic             found;
  logic             release_now;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT);
  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;
`endif

  arb_rr_pick #(.NUM(NUM), .NSIZE(NSIZE)) u_pick (
    .req    (arb.req),
    .rr_ptr (rr_ptr_q),
    .winner (winner),
    .found  (found)
  );

  // Next-state: arbitrate in IDLE, hold grant through ADDR/DATA, release on completion.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    grant_vld_d = grant_vld_q;
    grant_oh_d  = grant_oh_q;
    release_now = 1'b0;
`ifdef ARB_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (found) begin
          state_d     = ARB_ADDR;
          grant_idx_d = winner;
          grant_oh_d  = {{(NUM-1){1'b0}}, 1'b1} << winner;
          grant_vld_d = 1'b1;
        end
      end
      ARB_ADDR: begin
        if (arb.addr_hs) begin
          if (arb.release_evt) begin
            release_now = 1'b1;
          end else begin
            state_d = ARB_DATA;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
          end
        end
      end
      ARB_DATA: begin
        if (arb.release_evt) begin
          release_now = 1'b1;
`ifdef ARB_TIMEOUT_EN
        end else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          release_now   = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
`endif
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // Every exit to IDLE drops the grant and moves priority past the last winner.
    if (release_now) begin
      state_d     = ARB_IDLE;
      grant_vld_d = 1'b0;
      grant_oh_d  = '0;
      rr_ptr_d    = (grant_idx_q == NSIZE'(NUM - 1)) ? '0 : grant_idx_q + NSIZE'(1);
    end
    busy_d = (state_d != ARB_IDLE);
  end

  // State, priority pointer and registered grant outputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      grant_vld_q <= 1'b0;
      grant_oh_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      grant_vld_q <= grant_vld_d;
      grant_oh_q  <= grant_oh_d;
      busy_q      <= busy_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Timeout counter and its registered error pulse.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign arb.timeout_err = timeout_err_q;
`else
  assign arb.timeout_err = 1'b0;
`endif

  assign arb.grant_idx = grant_idx_q;
  assign arb.grant_vld = grant_vld_q;
  assign arb.grant_oh  = grant_oh_q;
  assign arb.busy      = busy_q;

endmodule

// File: tb/tb_axi4_rr_burst_arbiter.sv
// Bench for axi4_rr_burst_arbiter: driver pushes the expected winner of each
// grant into a queue; a negedge monitor pops it on every new grant.
module tb_axi4_rr_burst_arbiter;

  localparam int NUM = 8;
  localparam int TMO = 16;

  logic clock = 1'b0;
  logic rst_n;

  axi4_rr_burst_arbiter_if #(.NUM(NUM)) vif ();

  axi4_rr_burst_arbiter #(.NUM(NUM), .TIMEOUT(TMO)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .arb   (vif)
  );

  always #5 clock = ~clock;

  int vectors    = 0;
  int miscompares = 0;
  int exp_q[$];
  int ptr = 0;
  logic prev_vld = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    vectors++;
    if (act !== req_v) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, req_v, $time);
    end
  endtask

  // Reference rule: first requester at or after ptr, wrapping modulo NUM.
  function automatic int model_pick(input logic [NUM-1:0] r);
    for (int off = 0; off < NUM; off++) begin
      if (r[(ptr + off) % NUM]) return (ptr + off) % NUM;
    end
    return -1;
  endfunction

  // Monitor: a rising grant_vld must match the oldest expected winner.
  always @(negedge clock) begin
    if (vif.grant_vld && !prev_vld) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", {31'd0, vif.grant_vld}, 32'd0);
      end else begin
        int e;
        logic [NUM-1:0] e_oh;
        e = exp_q.pop_front();
        e_oh = '0;
        e_oh[e] = 1'b1;
        chk("grant_idx", 32'(vif.grant_idx), 32'(e));
        chk("grant_oh", 32'(vif.grant_oh), 32'(e_oh));
      end
    end
    if (!vif.grant_vld) begin
      chk("idle_oh_zero", 32'(vif.grant_oh), 32'd0);
      chk("idle_busy_zero", {31'd0, vif.busy}, 32'd0);
    end
`ifndef ARB_TIMEOUT_EN
    chk("timeout_err_tied", {31'd0, vif.timeout_err}, 32'd0);
`endif
    prev_vld = vif.grant_vld;
  end

  task automatic start_grant(input logic [NUM-1:0] r);
    int w;
    w = model_pick(r);
    exp_q.push_back(w);
    ptr = (w + 1) % NUM;
    vif.req = r;
    @(negedge clock);
    chk("grant_latency", {31'd0, vif.grant_vld}, 32'd1);
    chk("busy_on_grant", {31'd0, vif.busy}, 32'd1);
  endtask

  task automatic finish_txn(input int addr_gap, input bit combo, input int data_gap, input bit drop);
    if (drop) vif.req = '0;
    repeat (addr_gap) @(negedge clock);
    chk("held_in_addr", {31'd0, vif.grant_vld}, 32'd1);
    vif.addr_hs = 1'b1;
    vif.release_evt = combo;
    @(negedge clock);
    vif.addr_hs = 1'b0;
    vif.release_evt = 1'b0;
    if (!combo) begin
      repeat (data_gap) @(negedge clock);
      chk("held_in_data", {31'd0, vif.grant_vld}, 32'd1);
      vif.release_evt = 1'b1;
      @(negedge clock);
      vif.release_evt = 1'b0;
    end
    chk("released", {31'd0, vif.grant_vld}, 32'd0);
    vif.req = '0;
  endtask

  task automatic txn(input logic [NUM-1:0] r);
    start_grant(r);
    finish_txn($urandom_range(0, 2), 1'b0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NUM-1:0] r;
    int held;
    rst_n = 1'b0;
    vif.req = '0;
    vif.addr_hs = 1'b0;
    vif.release_evt = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_grant_vld", {31'd0, vif.grant_vld}, 32'd0);
    chk("rst_grant_idx", 32'(vif.grant_idx), 32'd0);
    chk("rst_busy", {31'd0, vif.busy}, 32'd0);
    chk("rst_timeout_err", {31'd0, vif.timeout_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clock);

    // Fairness with all requesting: 0..7 then 0 again.
    for (int i = 0; i < NUM + 1; i++) txn('1);
    // Single requester, then wrap from 7 to 0.
    txn(8'h04);
    txn(8'h40);
    txn(8'h81);
    txn(8'h81);
    // Address handshake and completion in the same cycle.
    start_grant(8'h0A);
    finish_txn(1, 1'b1, 0, 1'b0);
    // Completion pulse while idle is ignored.
    vif.release_evt = 1'b1;
    @(negedge clock);
    vif.release_evt = 1'b0;
    chk("idle_release_ignored", {31'd0, vif.grant_vld}, 32'd0);
    @(negedge clock);
    chk("idle_stays_idle", {31'd0, vif.busy}, 32'd0);

    // Long ARB_DATA without completion.
    start_grant(8'h10);
    vif.req = '0;
    vif.addr_hs = 1'b1;
    @(negedge clock);
    vif.addr_hs = 1'b0;
    held = 0;
`ifdef ARB_TIMEOUT_EN
    while (vif.grant_vld && held < 40) begin
      held++;
      @(negedge clock);
    end
    chk("timeout_cycles", 32'(held), 32'(TMO));
    chk("timeout_err_pulse", {31'd0, vif.timeout_err}, 32'd1);
    @(negedge clock);
    chk("timeout_err_single", {31'd0, vif.timeout_err}, 32'd0);
`else
    for (int i = 0; i < 120; i++) begin
      if (vif.grant_vld) held++;
      @(negedge clock);
    end
    chk("hold_no_timeout", 32'(held), 32'd120);
    vif.release_evt = 1'b1;
    @(negedge clock);
    vif.release_evt = 1'b0;
    chk("released_after_hold", {31'd0, vif.grant_vld}, 32'd0);
`endif

    // Asynchronous reset in ARB_DATA with master 5 granted.
    start_grant(8'h20);
    vif.addr_hs = 1'b1;
    @(negedge clock);
    vif.addr_hs = 1'b0;
    @(negedge clock);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_vld", {31'd0, vif.grant_vld}, 32'd0);
    chk("async_rst_idx", 32'(vif.grant_idx), 32'd0);
    chk("async_rst_oh", 32'(vif.grant_oh), 32'd0);
    chk("async_rst_busy", {31'd0, vif.busy}, 32'd0);
    vif.req = '0;
    ptr = 0;
    @(negedge clock);
    rst_n = 1'b1;
    @(negedge clock);
    txn(8'h20);

    // Randomized traffic with idle gaps and stray completion pulses.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          vif.release_evt = 1'($urandom_range(0, 1));
          @(negedge clock);
        end
        vif.release_evt = 1'b0;
      end
      r = NUM'($urandom);
      if (r == '0) r[$urandom_range(0, NUM - 1)] = 1'b1;
      start_grant(r);
      finish_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 4),
                 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clock);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
